// File: rtl/gpio8_out_seq.sv
// GPIO8 output sequencer: registered io_out/io_oe drives with bit ops and timed pulses.
// Optional macro GPIO8_OUT_PRESCALE_EN adds a prescale input that slows pulse counting.
module gpio8_out_seq #(
  parameter int         LEN_W     = 16,
  parameter logic [7:0] RESET_OUT = 8'h00,
  parameter logic [7:0] RESET_OE  = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef GPIO8_OUT_PRESCALE_EN
  input  logic [7:0]       prescale,
`endif
  output logic [7:0]       io_out,
  output logic [7:0]       io_oe,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_TOG   = 3'd4;
  localparam logic [2:0] OP_PULSE = 3'd5;
  localparam logic [2:0] OP_OE    = 3'd6;

  logic [0:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [7:0]       mask;
  logic             accept;
  logic             pulse_start;
  logic             tick;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state == HOLD);
  assign accept      = cmd_valid & cmd_ready;
  assign pulse_start = accept && (cmd_op == OP_PULSE);

`ifdef GPIO8_OUT_PRESCALE_EN
  logic [7:0] psc;

  // Free-running divider, restarted on pulse acceptance so every pulse gets whole ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= 8'h00;
    end else if (pulse_start || (psc == prescale)) begin
      psc <= 8'h00;
    end else begin
      psc <= psc + 8'h01;
    end
  end

  assign tick = (psc == prescale);
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mask   <= 8'h00;
      io_out <= RESET_OUT;
      io_oe  <= RESET_OE;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            done <= (cmd_op != OP_PULSE);
            case (cmd_op)
              OP_WRITE: io_out <= cmd_data;
              OP_SET:   io_out <= io_out | cmd_data;
              OP_CLR:   io_out <= io_out & ~cmd_data;
              OP_TOG:   io_out <= io_out ^ cmd_data;
              OP_OE:    io_oe  <= cmd_data;
              OP_PULSE: begin
                io_out <= io_out ^ cmd_data;
                mask   <= cmd_data;
                cnt    <= (cmd_len == '0) ? '0 : cmd_len - LEN_W'(1);
                state  <= HOLD;
              end
              OP_NOP:   ;
              default:  ;
            endcase
          end
        end
        HOLD: begin
          // The cycle in which cnt reaches zero on a tick is the last inverted cycle.
          if (tick) begin
            if (cnt == '0) begin
              io_out <= io_out ^ mask;
              state  <= IDLE;
              done   <= 1'b1;
            end else begin
              cnt <= cnt - LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
